// File: rtl/canvas_painter_pkg.sv
// Shared constants and types for the canvas painter: screen/canvas geometry,
// FSM state encoding and the 12-bit colour word.
package canvas_painter_pkg;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;
  localparam int unsigned CELL  = 10;
  localparam int unsigned COLS  = 64;
  localparam int unsigned ROWS  = 48;

  typedef enum logic {CLEAR, IDLE} state_t;

  typedef logic [11:0] rgb_t;

  // floor(v/10) as (v*205)>>11; exact for v <= 1028, so it covers the 10-bit range
  function automatic logic [6:0] div_cell(input logic [9:0] v);
    logic [17:0] p;
    p = 18'(v) * 18'd205;
    return 7'(p >> 11);
  endfunction

endpackage

// File: rtl/canvas_painter_if.sv
// Scan, cursor, paint and video signals between the sync/UI logic and the painter.
interface canvas_painter_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       paint_enable;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       clear_btn;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       busy;

  modport master (
    output x, y, video_on, box_x, box_y, paint_enable, red, green, blue, clear_btn,
    input  vga_r, vga_g, vga_b, busy
  );

  modport slave (
    input  x, y, video_on, box_x, box_y, paint_enable, red, green, blue, clear_btn,
    output vga_r, vga_g, vga_b, busy
  );
endinterface

// File: rtl/canvas_ram.sv
// Simple dual-port canvas memory: one write port, one registered read port,
// read-first on address collision so it maps onto block RAM.
module canvas_ram #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 3072
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/canvas_painter.sv
// Paint-on-grid VGA canvas: paints the cursor cell with the selected colour,
// overlays the cursor border on the scan-out and clears the canvas on demand.
module canvas_painter #(
  parameter int unsigned H_RES = canvas_painter_pkg::H_RES,
  parameter int unsigned V_RES = canvas_painter_pkg::V_RES,
  parameter int unsigned CELL  = canvas_painter_pkg::CELL,
  parameter int unsigned COLS  = canvas_painter_pkg::COLS,
  parameter int unsigned ROWS  = canvas_painter_pkg::ROWS
) (
  input logic             clk,
  input logic             reset,
  canvas_painter_if.slave bus
);
  import canvas_painter_pkg::*;

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);

  // Out-of-canvas coordinates all land on the last cell
  function automatic logic [AW-1:0] addr_of(input logic [9:0] px, input logic [9:0] py);
    logic [6:0] col;
    logic [6:0] row;
    col = div_cell(px);
    row = div_cell(py);
    if (32'(col) >= COLS || 32'(row) >= ROWS) return AW'(CELLS - 1);
    return AW'(32'(row) * COLS + 32'(col));
  endfunction

  state_t        state;
  logic [AW-1:0] cnt;
  logic          busy_q;

  logic sync1, sync2, sync3;
  logic clear_edge_c;

  logic [9:0] p1_x, p1_y;
  logic       p1_en;
  rgb_t       p1_rgb;

  logic          we_c;
  logic [AW-1:0] waddr_c;
  rgb_t          wdata_c;

  logic          on_c;
  logic          border_c;
  logic [AW-1:0] raddr_c;
  rgb_t          rdata;
  logic          von_d, brd_d;
  rgb_t          pix_q;

  assign clear_edge_c = sync2 & ~sync3;

  // Clear synchronizer (plus edge history) and paint stage P1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      p1_x   <= '0;
      p1_y   <= '0;
      p1_en  <= 1'b0;
      p1_rgb <= '0;
    end else begin
      sync1  <= bus.clear_btn;
      sync2  <= sync1;
      sync3  <= sync2;
      p1_x   <= bus.box_x;
      p1_y   <= bus.box_y;
      p1_en  <= bus.paint_enable;
      p1_rgb <= {bus.red, bus.green, bus.blue};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(CELLS - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end
        end
        IDLE: begin
          if (clear_edge_c) begin
            state  <= CLEAR;
            busy_q <= 1'b1;
            cnt    <= '0;
          end
        end
        default: begin
          state  <= CLEAR;
          busy_q <= 1'b1;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Write port: clear sweep owns it in CLEAR; a clear edge beats a paint in IDLE
  always_comb begin
    we_c    = 1'b0;
    waddr_c = cnt;
    wdata_c = '0;
    if (state == CLEAR) begin
      we_c = 1'b1;
    end else if (p1_en && !clear_edge_c) begin
      we_c    = 1'b1;
      waddr_c = addr_of(p1_x, p1_y);
      wdata_c = p1_rgb;
    end
  end

  // Cursor outline, compared at 11 bits so box+9 cannot wrap
  always_comb begin
    logic [10:0] bx, by, bxe, bye, sx, sy;
    bx  = 11'(bus.box_x);
    by  = 11'(bus.box_y);
    bxe = bx + 11'(CELL - 1);
    bye = by + 11'(CELL - 1);
    sx  = 11'(bus.x);
    sy  = 11'(bus.y);
    border_c = (sx >= bx) && (sx <= bxe) && (sy >= by) && (sy <= bye) &&
               ((sx == bx) || (sx == bxe) || (sy == by) || (sy == bye));
  end

  assign on_c    = bus.video_on && (32'(bus.x) < H_RES) && (32'(bus.y) < V_RES);
  assign raddr_c = addr_of(bus.x, bus.y);

  canvas_ram #(.AW(AW), .DW(12), .DEPTH(CELLS)) u_ram (
    .clk   (clk),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .re    (on_c),
    .raddr (raddr_c),
    .rdata (rdata)
  );

  // R1 side-band alongside the RAM read, then the R2 output mux
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      von_d <= 1'b0;
      brd_d <= 1'b0;
      pix_q <= '0;
    end else begin
      von_d <= on_c;
      brd_d <= border_c;
      if (!von_d)     pix_q <= '0;
      else if (brd_d) pix_q <= 12'hFFF;
      else            pix_q <= rdata;
    end
  end

  assign bus.vga_r = pix_q[11:8];
  assign bus.vga_g = pix_q[7:4];
  assign bus.vga_b = pix_q[3:0];
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_canvas_painter.sv
// Directed bench for canvas_painter: stimulus pushes timed expectations into a
// scoreboard, a negedge monitor pops and compares pixels and busy.
module tb_canvas_painter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  canvas_painter_if bus();

  canvas_painter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    bit          is_busy;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic push(input int unsigned at, input bit is_busy, input logic [11:0] val,
                      input string name);
    exp_t e;
    e.at = at; e.is_busy = is_busy; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic busy_at(input int unsigned at, input bit v, input string name);
    push(at, 1'b1, {11'b0, v}, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int sx, input int sy, input bit von, input logic [11:0] e,
                      input string name);
    @(negedge clk);
    bus.x        = 10'(sx);
    bus.y        = 10'(sy);
    bus.video_on = von;
    push(cyc + 2, 1'b0, e, name);
  endtask

  // Monitor: compare every expectation due on this cycle
  always @(negedge clk) begin
    logic [11:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        act = sb[i].is_busy ? {11'b0, bus.busy} : {bus.vga_r, bus.vga_g, bus.vga_b};
        vectors++;
        if (sb[i].at < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sb[i].name,
                   sb[i].at, cyc);
        end else if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s: got %03h want %03h at cycle %0d", sb[i].name, act, sb[i].val,
                   cyc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached with %0d pending", sb.size());
    $fatal(1);
  end

  initial begin
    int unsigned c0, c1, e;
    reset            = 1'b1;
    bus.x            = '0;
    bus.y            = '0;
    bus.video_on     = 1'b0;
    bus.box_x        = 10'd1000;
    bus.box_y        = 10'd1000;
    bus.paint_enable = 1'b0;
    bus.red          = '0;
    bus.green        = '0;
    bus.blue         = '0;
    bus.clear_btn    = 1'b0;

    // Reset state
    @(negedge clk);
    busy_at(cyc + 1, 1'b1, "rst_busy");
    push(cyc + 1, 1'b0, 12'h000, "rst_vga");
    idle(2);

    // Reset release, then reset again at counter 1000
    reset = 1'b0;
    c0 = cyc;
    busy_at(c0 + 1, 1'b1, "clr0_busy_start");
    idle(1000);
    reset = 1'b1;
    busy_at(cyc + 1, 1'b1, "rst_mid_clear_busy");
    idle(2);
    reset = 1'b0;
    c1 = cyc;
    busy_at(c1 + 1,    1'b1, "clr1_busy_start");
    busy_at(c1 + 3071, 1'b1, "clr1_busy_last");
    busy_at(c1 + 3072, 1'b0, "clr1_busy_done");
    idle(3075);

    scan(0, 0, 1'b1, 12'h000, "init_cell0");
    scan(639, 479, 1'b1, 12'h000, "init_cell3071");
    scan(312, 232, 1'b1, 12'h000, "init_cell1503");

    // Single-cycle paint of F00 at box 315/235 -> cell 1503
    bus.box_x = 10'd315; bus.box_y = 10'd235;
    bus.red = 4'hF; bus.green = 4'h0; bus.blue = 4'h0;
    bus.paint_enable = 1'b1;
    scan(312, 232, 1'b1, 12'h000, "read_first_collision");
    bus.paint_enable = 1'b0;
    scan(312, 232, 1'b1, 12'hF00, "paint_f00");
    scan(315, 240, 1'b1, 12'hFFF, "border_left");
    scan(318, 240, 1'b1, 12'h000, "inside_cell1567");
    scan(316, 236, 1'b1, 12'hF00, "inside_painted");
    scan(324, 244, 1'b1, 12'hFFF, "border_corner_br");
    scan(320, 235, 1'b1, 12'hFFF, "border_top");
    scan(325, 240, 1'b1, 12'h000, "right_of_box");
    scan(320, 234, 1'b1, 12'h000, "above_box");
    scan(315, 240, 1'b0, 12'h000, "blank_on_border");
    scan(316, 236, 1'b0, 12'h000, "blank_on_paint");
    scan(1023, 1023, 1'b0, 12'h000, "blank_far");

    // Boundary paints on consecutive cycles: cell 3071, cell 0, cell 1
    bus.box_x = 10'd639; bus.box_y = 10'd479;
    {bus.red, bus.green, bus.blue} = 12'h123;
    bus.paint_enable = 1'b1;
    idle(1);
    bus.box_x = 10'd9; bus.box_y = 10'd0;
    {bus.red, bus.green, bus.blue} = 12'h5A3;
    idle(1);
    bus.box_x = 10'd10; bus.box_y = 10'd0;
    {bus.red, bus.green, bus.blue} = 12'h0C7;
    idle(1);
    bus.paint_enable = 1'b0;
    bus.box_x = 10'd1000; bus.box_y = 10'd1000;
    idle(2);
    scan(635, 475, 1'b1, 12'h123, "paint_cell3071");
    scan(9, 3, 1'b1, 12'h5A3, "col_floor_9");
    scan(10, 3, 1'b1, 12'h0C7, "col_floor_10");
    scan(19, 9, 1'b1, 12'h0C7, "col_floor_19");
    scan(20, 9, 1'b1, 12'h000, "col_floor_20");

    // Clear while painting 0F0 at 5/5, with a retrigger during CLEAR
    bus.box_x = 10'd5; bus.box_y = 10'd5;
    {bus.red, bus.green, bus.blue} = 12'h0F0;
    bus.paint_enable = 1'b1;
    idle(3);
    bus.clear_btn = 1'b1;
    e = cyc;
    busy_at(e + 2,    1'b0, "clr_btn_pre");
    busy_at(e + 3,    1'b1, "clr_btn_busy");
    busy_at(e + 3074, 1'b1, "clr_btn_busy_last");
    busy_at(e + 3075, 1'b0, "clr_btn_done_no_restart");
    idle(20);
    bus.paint_enable = 1'b0;
    bus.box_x = 10'd1000; bus.box_y = 10'd1000;
    idle(80);
    bus.clear_btn = 1'b0;
    idle(10);
    bus.clear_btn = 1'b1;
    idle(10);
    bus.clear_btn = 1'b0;
    idle(3000);

    for (int r = 0; r < 48; r++)
      for (int c = 0; c < 64; c++)
        scan(c * 10 + 3, r * 10 + 7, 1'b1, 12'h000, "canvas_zero");

    idle(4);
    while (sb.size() > 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: never checked (due cycle %0d)", sb[0].name, sb[0].at);
      sb.delete(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
